// File: rtl/instr_loader.sv
// instr_loader: writer side of the instruction memory.
//
// Takes a byte stream over a valid/ready handshake, reads a 4-byte
// little-endian word count N, then assembles N little-endian 32-bit words and
// writes them to the instruction memory at byte addresses 0, 4, 8, ...
// The core is held in reset (cpu_rst=1) until the whole image has been
// written. A count of zero finishes immediately. A count above MAX_WORDS
// rejects the image, and the loader then stays in the error state until rst.
//
// Optional build macro: INSTR_LOADER_CHECKSUM_EN
//   When this macro is defined, the image is followed by one extra byte. That
//   byte must equal the mod-256 sum of all data bytes. The header bytes are
//   not part of the sum. A match leads to DONE. A mismatch leads to ERR.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_data    in   [7:0] stream byte
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts a byte this cycle
//   mem_we     out  one-cycle instruction memory write pulse
//   mem_addr   out  [ADDR_WIDTH-1:0] write byte address (word index * 4)
//   mem_wdata  out  [DATA_WIDTH-1:0] write data
//   cpu_rst    out  core reset, 1 = hold core
//   done       out  image loaded successfully
//   error      out  image rejected
module instr_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  localparam int IW = $clog2(MAX_WORDS) + 1;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
`ifdef INSTR_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q;
  logic [IW-1:0]         idx_q;
  logic [31:0]           count_q;
  logic [23:0]           word_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  cpu_rst_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic        ready_st;
  logic        accept;
  logic        last_byte;
  logic        last_word;
  logic [31:0] hdr_word;

  // Ready depends only on the state. It is independent of in_valid.
  always_comb begin
    ready_st = (state_q == S_HDR) || (state_q == S_DATA);
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (state_q == S_CSUM) ready_st = 1'b1;
`endif
  end

  assign accept    = in_valid && ready_st;
  assign last_byte = (byte_cnt_q == 2'd3);
  // The header fills from the top, so the first byte ends up in bits [7:0].
  assign hdr_word  = {in_data, count_q[31:8]};
  assign last_word = ((32'(idx_q) + 32'd1) == count_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_HDR;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR: begin
        if (accept && last_byte) begin
          if (hdr_word == 32'd0)
`ifdef INSTR_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          else if (hdr_word > 32'(MAX_WORDS))
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && last_byte && last_word)
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = ready_st && !rst;
    done      = (state_q == S_DONE);
    error     = (state_q == S_ERR);
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    cpu_rst   = cpu_rst_q;
  end

  // Datapath: byte counting, word assembly and the registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q  <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      word_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      // Release the core one cycle after DONE, once the final write has landed.
      cpu_rst_q <= (state_q != S_DONE);
      if (accept && (state_q == S_HDR)) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        count_q    <= hdr_word;
      end
      if (accept && (state_q == S_DATA)) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_q     <= csum_q + in_data;
`endif
        if (last_byte) begin
          mem_we_q    <= 1'b1;
          mem_wdata_q <= {in_data, word_q};
          mem_addr_q  <= ADDR_WIDTH'(idx_q) << 2;
          idx_q       <= idx_q + 1'b1;
        end else begin
          word_q <= {in_data, word_q[23:8]};
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: log every write pulse and the cycles where done rises and cpu_rst falls.
  int          cyc = 0;
  int          done_rise_cyc = -1;
  int          crst_fall_cyc = -1;
  int          last_we_cyc = -1;
  logic        done_prev = 1'b0;
  logic        crst_prev = 1'b1;
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
      last_we_cyc = cyc;
    end
    if (done === 1'b1 && !done_prev) done_rise_cyc = cyc;
    if (cpu_rst === 1'b0 && crst_prev) crst_fall_cyc = cyc;
    done_prev = (done === 1'b1);
    crst_prev = (cpu_rst !== 1'b0);
  end

  // Stimulus and reference model state
  logic [7:0]  stream[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic        exp_done;
  logic        exp_err;

  function automatic logic [7:0] sum8(input int first, input int nbytes);
    logic [7:0] s = '0;
    for (int i = first; i < first + nbytes; i++) s = s + stream[i];
    return s;
  endfunction

  // Reference model: read the image straight from the stream format rules.
  task automatic model_stream();
    logic [31:0] n;
    n = {stream[3], stream[2], stream[1], stream[0]};
    exp_a.delete();
    exp_d.delete();
    if (n > MAXW) begin
      exp_err = 1'b1;
      exp_done = 1'b0;
    end else begin
      for (int unsigned i = 0; i < n; i++) begin
        exp_a.push_back(4 * i);
        exp_d.push_back({stream[4+4*i+3], stream[4+4*i+2], stream[4+4*i+1], stream[4+4*i]});
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      exp_done = (sum8(4, 4 * int'(n)) == stream[4 + 4 * int'(n)]);
`else
      exp_done = 1'b1;
`endif
      exp_err = !exp_done;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = b;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_timeout: in_ready stayed %b, required 1", in_ready);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic drive_stream(input int max_stall);
    foreach (stream[i]) begin
      int k = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      repeat (k) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
      end
      send_byte(stream[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL end_timeout: done=%b error=%b, required one of them 1", done, error);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic load_basic_stream();
    stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
               8'h93, 8'h05, 8'h20, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
    stream.push_back(sum8(4, 8));
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", error); end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = wr_a.size();
    load_basic_stream();
    drive_stream(0);
    wait_end();
    n_cmp++; if (wr_a.size() - base !== 2) begin n_bad++; $display("FAIL basic_nwrites: got %0d want 2", wr_a.size() - base); end
    if (wr_a.size() - base >= 2) begin
      n_cmp++; if (wr_a[base] !== 32'h0) begin n_bad++; $display("FAIL basic_addr0: got %h want 0", wr_a[base]); end
      n_cmp++; if (wr_d[base] !== 32'h00100513) begin n_bad++; $display("FAIL basic_data0: got %h want 00100513", wr_d[base]); end
      n_cmp++; if (wr_a[base+1] !== 32'h4) begin n_bad++; $display("FAIL basic_addr1: got %h want 4", wr_a[base+1]); end
      n_cmp++; if (wr_d[base+1] !== 32'h00200593) begin n_bad++; $display("FAIL basic_data1: got %h want 00200593", wr_d[base+1]); end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (cpu_rst !== 1'b0) begin n_bad++; $display("FAIL basic_cpu_rst: got %b want 0", cpu_rst); end
    n_cmp++; if (crst_fall_cyc !== done_rise_cyc + 1) begin n_bad++; $display("FAIL basic_crst_lag: got cycle %0d want %0d", crst_fall_cyc, done_rise_cyc + 1); end
`ifndef INSTR_LOADER_CHECKSUM_EN
    n_cmp++; if (done_rise_cyc !== last_we_cyc) begin n_bad++; $display("FAIL basic_done_with_last_we: got cycle %0d want %0d", done_rise_cyc, last_we_cyc); end
`endif
  endtask

  task automatic test_stall();
    int base;
    int ready_low = 0;
    do_reset();
    base = wr_a.size();
    load_basic_stream();
    foreach (stream[i]) begin
      repeat (3) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
        if (in_ready !== 1'b1) ready_low++;
      end
      send_byte(stream[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_end();
    n_cmp++; if (ready_low !== 0) begin n_bad++; $display("FAIL stall_ready: in_ready low on %0d stall cycles, required 0", ready_low); end
    n_cmp++; if (wr_a.size() - base !== 2) begin n_bad++; $display("FAIL stall_nwrites: got %0d want 2", wr_a.size() - base); end
    if (wr_a.size() - base >= 2) begin
      n_cmp++; if (wr_d[base] !== 32'h00100513 || wr_a[base] !== 32'h0) begin n_bad++; $display("FAIL stall_w0: got %h@%h want 00100513@0", wr_d[base], wr_a[base]); end
      n_cmp++; if (wr_d[base+1] !== 32'h00200593 || wr_a[base+1] !== 32'h4) begin n_bad++; $display("FAIL stall_w1: got %h@%h want 00200593@4", wr_d[base+1], wr_a[base+1]); end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %b want 1", done); end
  endtask

  task automatic test_zero_count();
    int base;
    do_reset();
    base = wr_a.size();
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    drive_stream(0);
    wait_end();
    n_cmp++; if (wr_a.size() - base !== 0) begin n_bad++; $display("FAIL zero_nwrites: got %0d want 0", wr_a.size() - base); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL zero_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (crst_fall_cyc !== done_rise_cyc + 1) begin n_bad++; $display("FAIL zero_crst_lag: got cycle %0d want %0d", crst_fall_cyc, done_rise_cyc + 1); end
  endtask

  task automatic test_oversize();
    int base;
    int ready_hi = 0;
    do_reset();
    base = wr_a.size();
    stream = '{8'h01, 8'h01, 8'h00, 8'h00};
    drive_stream(0);
    wait_end();
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'($urandom);
      if (in_ready !== 1'b0) ready_hi++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL over_error: got %b want 1", error); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL over_done: got %b want 0", done); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL over_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (wr_a.size() - base !== 0) begin n_bad++; $display("FAIL over_nwrites: got %0d want 0", wr_a.size() - base); end
    n_cmp++; if (ready_hi !== 0) begin n_bad++; $display("FAIL over_in_ready: high on %0d cycles, required 0", ready_hi); end
  endtask

  task automatic test_midload_reset();
    int base;
    do_reset();
    load_basic_stream();
    drive_stream(0);
    wait_end();
    n_cmp++; if (cpu_rst !== 1'b0) begin n_bad++; $display("FAIL mid_pre_cpu_rst: got %b want 0", cpu_rst); end
    // Assert rst between clock edges, so an immediate response shows the reset is asynchronous.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL mid_async_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_async_done: got %b want 0", done); end
    @(negedge clk);
    rst = 1'b0;
    base = wr_a.size();
    load_basic_stream();
    stream = stream[0:5];
    drive_stream(0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL mid_partial_cpu_rst: got %b want 1", cpu_rst); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (wr_a.size() - base !== 0) begin n_bad++; $display("FAIL mid_partial_nwrites: got %0d want 0", wr_a.size() - base); end
    base = wr_a.size();
    load_basic_stream();
    drive_stream(1);
    wait_end();
    n_cmp++; if (wr_a.size() - base !== 2) begin n_bad++; $display("FAIL mid_reload_nwrites: got %0d want 2", wr_a.size() - base); end
    if (wr_a.size() - base >= 2) begin
      n_cmp++; if (wr_a[base] !== 32'h0 || wr_a[base+1] !== 32'h4) begin n_bad++; $display("FAIL mid_reload_addrs: got %h,%h want 0,4", wr_a[base], wr_a[base+1]); end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mid_reload_done: got %b want 1", done); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int base;
      logic [31:0] n;
      do_reset();
      base = wr_a.size();
      stream.delete();
      if (it == 0)      n = MAXW;
      else if (it == 1) n = MAXW + 1 + $urandom_range(1000, 0);
      else              n = $urandom_range(6, 0);
      for (int b = 0; b < 4; b++) stream.push_back(n[8*b +: 8]);
      if (n <= MAXW) begin
        for (int unsigned i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
`ifdef INSTR_LOADER_CHECKSUM_EN
        stream.push_back(sum8(4, 4 * int'(n)) + ((it % 3 == 2) ? 8'd1 : 8'd0));
`endif
      end
      model_stream();
      drive_stream((it == 0) ? 0 : 3);
      wait_end();
      n_cmp++;
      if (wr_a.size() - base !== exp_a.size()) begin
        n_bad++; $display("FAIL rand%0d_nwrites: got %0d want %0d", it, wr_a.size() - base, exp_a.size());
      end else begin
        foreach (exp_a[i]) begin
          n_cmp++;
          if (wr_a[base+i] !== exp_a[i] || wr_d[base+i] !== exp_d[i]) begin
            n_bad++; $display("FAIL rand%0d_write%0d: got %h@%h want %h@%h", it, i, wr_d[base+i], wr_a[base+i], exp_d[i], exp_a[i]);
          end
        end
      end
      n_cmp++; if (done !== exp_done) begin n_bad++; $display("FAIL rand%0d_done: got %b want %b", it, done, exp_done); end
      n_cmp++; if (error !== exp_err) begin n_bad++; $display("FAIL rand%0d_error: got %b want %b", it, error, exp_err); end
      n_cmp++; if (cpu_rst !== !exp_done) begin n_bad++; $display("FAIL rand%0d_cpu_rst: got %b want %b", it, cpu_rst, !exp_done); end
    end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int base;
    do_reset();
    base = wr_a.size();
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28};
    drive_stream(0);
    wait_end();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL csum_ok_done: got %b want 1", done); end
    n_cmp++; if (wr_a.size() - base !== 1) begin n_bad++; $display("FAIL csum_ok_nwrites: got %0d want 1", wr_a.size() - base); end
    do_reset();
    base = wr_a.size();
    stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h27};
    drive_stream(0);
    wait_end();
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL csum_bad_error: got %b want 1", error); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL csum_bad_cpu_rst: got %b want 1", cpu_rst); end
    n_cmp++; if (wr_a.size() - base !== 1) begin n_bad++; $display("FAIL csum_bad_nwrites: got %0d want 1", wr_a.size() - base); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_count();
    test_oversize();
    test_midload_reset();
    test_random();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
